// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and helpers for the MEM pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memState_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size code 11 behaves as a word.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        case (size)
            SZ_BYTE: isMisaligned = 1'b0;
            SZ_HALF: isMisaligned = addrLo[0];
            default: isMisaligned = (addrLo != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_align
// Brief    : Lane selection and zero/sign extension of load read data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addrLo,
    input  logic [1:0]  size,
    input  logic        signExt,
    output logic [31:0] loadData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = rdata[7:0];
        w_half   = addrLo[1] ? rdata[31:16] : rdata[15:0];
        loadData = rdata;
        case (addrLo)
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            2'd3:    w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
        case (size)
            SZ_BYTE: loadData = {{24{signExt & w_byte[7]}}, w_byte};
            SZ_HALF: loadData = {{16{signExt & w_half[15]}}, w_half};
            default: loadData = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : MEM pipeline stage; req/ack data-memory access with stall and
//            bubble generation. Optional WAIT timeout via MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        MemReadIN,
    input  logic        MemWriteIN,
    input  logic [1:0]  MemSizeIN,
    input  logic        MemSignedIN,
    input  logic        MemtoRegIN,
    input  logic        RegWriteIN,
    input  logic [31:0] ALU_IN,
    input  logic [31:0] WriteDataIN,
    input  logic [4:0]  DestinoIN,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        MemtoRegOUT,
    output logic        RegWriteOUT,
    output logic [31:0] dataOUT,
    output logic [31:0] ALU_OUT,
    output logic [4:0]  DestinoOUT,
    output logic        stall_out,
    output logic        misalign_out,
    output logic        mem_err
);

    memState_t   r_state, w_next;
    logic [31:0] r_alu, r_wdata, r_rdata;
    logic [3:0]  r_be;
    logic [4:0]  r_dest;
    logic [1:0]  r_size;
    logic        r_req, r_we, r_isLoad, r_signed, r_memToReg, r_regWrite, r_err;

    logic        w_memOp, w_mis, w_enter, w_ackTake, w_abort, w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_loadData;

    assign w_memOp = valid_in & (MemReadIN | MemWriteIN);
    assign w_mis   = isMisaligned(MemSizeIN, ALU_IN[1:0]);

    // Store lane steering; loads drive zero write data.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataIN;
        case (MemSizeIN)
            SZ_BYTE: begin
                w_be    = 4'b0001 << ALU_IN[1:0];
                w_wdata = {4{WriteDataIN[7:0]}};
            end
            SZ_HALF: begin
                w_be    = ALU_IN[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WriteDataIN[15:0]}};
            end
            default: ;
        endcase
        if (!MemWriteIN) w_wdata = '0;
    end

    mem_load_align u_align (
        .rdata    (mem_rdata),
        .addrLo   (r_alu[1:0]),
        .size     (r_size),
        .signExt  (r_signed),
        .loadData (w_loadData)
    );

`ifdef MEM_TIMEOUT_EN
    logic [15:0] r_timer;

    assign w_timeout = (r_timer == 16'(TIMEOUT_CYCLES - 1));
    assign mem_err   = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n)                r_timer <= '0;
        else if (w_enter)          r_timer <= '0;
        else if (r_state == WAIT)  r_timer <= r_timer + 16'd1;
    end
`else
    logic w_unusedTimeout;
    assign w_unusedTimeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout       = 1'b0;
    assign mem_err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_enter      = 1'b0;
        w_ackTake    = 1'b0;
        w_abort      = 1'b0;
        stall_out    = 1'b0;
        misalign_out = 1'b0;
        RegWriteOUT  = 1'b0;
        MemtoRegOUT  = 1'b0;
        dataOUT      = '0;
        ALU_OUT      = ALU_IN;
        DestinoOUT   = DestinoIN;
        case (r_state)
            IDLE: begin
                if (!w_memOp) begin
                    RegWriteOUT = RegWriteIN & valid_in;
                    MemtoRegOUT = MemtoRegIN & valid_in;
                end else if (w_mis) begin
                    misalign_out = 1'b1;
                end else begin
                    stall_out = 1'b1;
                    w_enter   = 1'b1;
                    w_next    = WAIT;
                end
            end
            WAIT: begin
                stall_out  = 1'b1;
                ALU_OUT    = r_alu;
                DestinoOUT = r_dest;
                // An ack arriving on the timeout cycle takes priority.
                if (mem_ack) begin
                    w_ackTake = 1'b1;
                    w_next    = DONE;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = DONE;
                end
            end
            DONE: begin
                RegWriteOUT = r_regWrite & ~r_err;
                MemtoRegOUT = r_memToReg;
                dataOUT     = r_rdata;
                ALU_OUT     = r_alu;
                DestinoOUT  = r_dest;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_be       <= '0;
            r_dest     <= '0;
            r_size     <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_isLoad   <= 1'b0;
            r_signed   <= 1'b0;
            r_memToReg <= 1'b0;
            r_regWrite <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == DONE) r_err <= 1'b0;
            if (w_enter) begin
                r_alu      <= ALU_IN;
                r_wdata    <= w_wdata;
                r_rdata    <= '0;
                r_be       <= w_be;
                r_dest     <= DestinoIN;
                r_size     <= MemSizeIN;
                r_req      <= 1'b1;
                r_we       <= MemWriteIN;
                r_isLoad   <= MemReadIN;
                r_signed   <= MemSignedIN;
                r_memToReg <= MemtoRegIN;
                r_regWrite <= RegWriteIN;
                r_err      <= 1'b0;
            end
            if (w_ackTake) begin
                r_req <= 1'b0;
                r_we  <= 1'b0;
                if (r_isLoad) r_rdata <= w_loadData;
            end
            if (w_abort) begin
                r_req <= 1'b0;
                r_we  <= 1'b0;
                r_err <= 1'b1;
            end
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = {r_alu[31:2], 2'b00};
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Self-checking bench for mem_access_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;
    import mem_pkg::*;

    localparam int TB_TO = 4;

    logic        clk, rst_n, valid_in, MemReadIN, MemWriteIN, MemSignedIN;
    logic        MemtoRegIN, RegWriteIN, mem_ack;
    logic [1:0]  MemSizeIN;
    logic [31:0] ALU_IN, WriteDataIN, mem_rdata;
    logic [4:0]  DestinoIN;
    logic        mem_req, mem_we, MemtoRegOUT, RegWriteOUT, stall_out, misalign_out, mem_err;
    logic [31:0] mem_addr, mem_wdata, dataOUT, ALU_OUT;
    logic [3:0]  mem_be;
    logic [4:0]  DestinoOUT;

    mem_access_stage #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .MemReadIN(MemReadIN), .MemWriteIN(MemWriteIN), .MemSizeIN(MemSizeIN),
        .MemSignedIN(MemSignedIN), .MemtoRegIN(MemtoRegIN), .RegWriteIN(RegWriteIN),
        .ALU_IN(ALU_IN), .WriteDataIN(WriteDataIN), .DestinoIN(DestinoIN),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .MemtoRegOUT(MemtoRegOUT), .RegWriteOUT(RegWriteOUT), .dataOUT(dataOUT),
        .ALU_OUT(ALU_OUT), .DestinoOUT(DestinoOUT), .stall_out(stall_out),
        .misalign_out(misalign_out), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] alu;
        logic [4:0]  dest;
        logic        rw;
        logic        m2r;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        valid, rd, wr;
        logic [1:0]  size;
        logic        sgn, m2r, rw;
        logic [31:0] alu;
        logic [4:0]  dest;
        logic        eStall, eMis, eRw, eM2r;
        logic [31:0] eAlu;
        logic [4:0]  eDest;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        valid_in = 0; MemReadIN = 0; MemWriteIN = 0; MemSizeIN = 0; MemSignedIN = 0;
        MemtoRegIN = 0; RegWriteIN = 0; ALU_IN = 0; WriteDataIN = 0; DestinoIN = 0;
    endtask

    // Called #1 after a posedge; returns #1 after the posedge ending DONE.
    task automatic memOp(input string nm, input logic rd, input logic wr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] dest, input logic rw, input logic [31:0] rdata,
                         input int ackDelay, input logic [31:0] expData,
                         input logic [3:0] expBe, input logic [31:0] expWd);
        int k = 0;
        int stallCnt = 0;
        int expStall;
        bit done = 0;
        bit rwLeak = 0;
        exp_t e;
        valid_in = 1; MemReadIN = rd; MemWriteIN = wr; MemSizeIN = size; MemSignedIN = sgn;
        MemtoRegIN = rd; RegWriteIN = rw; ALU_IN = addr; WriteDataIN = wd; DestinoIN = dest;
        e.data = (ackDelay == 0) ? 32'h0 : expData;
        e.alu  = addr; e.dest = dest; e.m2r = rd;
        e.rw   = (ackDelay == 0) ? 1'b0 : rw;
        e.err  = (ackDelay == 0);
        sb.push_back(e);
        expStall = (ackDelay == 0) ? TB_TO + 1 : ackDelay + 1;
        while (!done && k < 24) begin
            @(negedge clk);
            if (stall_out) begin
                stallCnt++;
                if (RegWriteOUT) rwLeak = 1;
                if (k == 0) chk({nm, " req_entry"}, 32'(mem_req), 32'h0);
                if (k == 1) begin
                    chk({nm, " req"},   32'(mem_req),   32'h1);
                    chk({nm, " we"},    32'(mem_we),    32'(wr));
                    chk({nm, " addr"},  mem_addr,       {addr[31:2], 2'b00});
                    chk({nm, " be"},    32'(mem_be),    32'(expBe));
                    chk({nm, " wdata"}, mem_wdata,      expWd);
                end
                @(posedge clk); #1;
                mem_ack = 0;
                k++;
                if (ackDelay != 0 && k == ackDelay) begin
                    mem_ack = 1; mem_rdata = rdata;
                end
                if (ackDelay != 0 && k == ackDelay + 1) begin
                    ALU_IN = 32'hFFFF_0000; DestinoIN = 5'd0;
                end
            end else begin
                done = 1;
            end
        end
        chk({nm, " stall_cycles"}, 32'(stallCnt), 32'(expStall));
        chk({nm, " rw_in_stall"},  32'(rwLeak), 32'h0);
        if (sb.size() == 0) begin
            chk({nm, " sb_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            chk({nm, " dataOUT"},     dataOUT,            e.data);
            chk({nm, " RegWriteOUT"}, 32'(RegWriteOUT),   32'(e.rw));
            chk({nm, " MemtoRegOUT"}, 32'(MemtoRegOUT),   32'(e.m2r));
            chk({nm, " DestinoOUT"},  32'(DestinoOUT),    32'(e.dest));
            chk({nm, " ALU_OUT"},     ALU_OUT,            e.alu);
            chk({nm, " req_done"},    32'(mem_req),       32'h0);
`ifdef MEM_TIMEOUT_EN
            chk({nm, " mem_err"},     32'(mem_err),       32'(e.err));
`else
            chk({nm, " mem_err"},     32'(mem_err),       32'h0);
`endif
        end
        @(posedge clk); #1;
        mem_ack = 0;
        idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{valid:1, rd:0, wr:0, size:SZ_WORD, sgn:0, m2r:0, rw:1, alu:32'h1234, dest:5'd5,
                    eStall:0, eMis:0, eRw:1, eM2r:0, eAlu:32'h1234, eDest:5'd5};
        vecs[1] = '{valid:0, rd:0, wr:0, size:SZ_WORD, sgn:0, m2r:1, rw:1, alu:32'h55, dest:5'd9,
                    eStall:0, eMis:0, eRw:0, eM2r:0, eAlu:32'h55, eDest:5'd9};
        vecs[2] = '{valid:1, rd:1, wr:0, size:SZ_WORD, sgn:0, m2r:1, rw:1, alu:32'h101, dest:5'd3,
                    eStall:0, eMis:1, eRw:0, eM2r:0, eAlu:32'h101, eDest:5'd3};
        vecs[3] = '{valid:1, rd:1, wr:0, size:SZ_HALF, sgn:1, m2r:1, rw:1, alu:32'h203, dest:5'd4,
                    eStall:0, eMis:1, eRw:0, eM2r:0, eAlu:32'h203, eDest:5'd4};
        vecs[4] = '{valid:1, rd:0, wr:1, size:2'b11, sgn:0, m2r:0, rw:0, alu:32'h302, dest:5'd0,
                    eStall:0, eMis:1, eRw:0, eM2r:0, eAlu:32'h302, eDest:5'd0};
        vecs[5] = '{valid:1, rd:0, wr:0, size:SZ_BYTE, sgn:0, m2r:1, rw:1, alu:32'hFFFF_FFFF, dest:5'd31,
                    eStall:0, eMis:0, eRw:1, eM2r:1, eAlu:32'hFFFF_FFFF, eDest:5'd31};

        idle();
        rst_n = 0; mem_ack = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst mem_req",   32'(mem_req),   32'h0);
        chk("rst mem_we",    32'(mem_we),    32'h0);
        chk("rst mem_be",    32'(mem_be),    32'h0);
        chk("rst mem_addr",  mem_addr,       32'h0);
        chk("rst mem_wdata", mem_wdata,      32'h0);
        chk("rst mem_err",   32'(mem_err),   32'h0);
        chk("rst misalign",  32'(misalign_out), 32'h0);
        @(posedge clk); #1;
        rst_n = 1;

        for (int i = 0; i < 6; i++) begin
            valid_in = vecs[i].valid; MemReadIN = vecs[i].rd; MemWriteIN = vecs[i].wr;
            MemSizeIN = vecs[i].size; MemSignedIN = vecs[i].sgn; MemtoRegIN = vecs[i].m2r;
            RegWriteIN = vecs[i].rw; ALU_IN = vecs[i].alu; DestinoIN = vecs[i].dest;
            WriteDataIN = 32'hCAFE_F00D;
            @(negedge clk);
            chk($sformatf("vec%0d stall", i),    32'(stall_out),    32'(vecs[i].eStall));
            chk($sformatf("vec%0d misalign", i), 32'(misalign_out), 32'(vecs[i].eMis));
            chk($sformatf("vec%0d RegWrite", i), 32'(RegWriteOUT),  32'(vecs[i].eRw));
            chk($sformatf("vec%0d MemtoReg", i), 32'(MemtoRegOUT),  32'(vecs[i].eM2r));
            chk($sformatf("vec%0d ALU_OUT", i),  ALU_OUT,           vecs[i].eAlu);
            chk($sformatf("vec%0d Destino", i),  32'(DestinoOUT),   32'(vecs[i].eDest));
            chk($sformatf("vec%0d dataOUT", i),  dataOUT,           32'h0);
            @(posedge clk); #1;
            idle();
            @(negedge clk);
            chk($sformatf("vec%0d req_after", i),   32'(mem_req),   32'h0);
            chk($sformatf("vec%0d stall_after", i), 32'(stall_out), 32'h0);
            @(posedge clk); #1;
        end

        memOp("LW",  1, 0, SZ_WORD, 0, 32'h100, 32'h0,        5'd7,  1, 32'hDEAD_BEEF, 1,
              32'hDEAD_BEEF, 4'b1111, 32'h0);
        memOp("LB",  1, 0, SZ_BYTE, 1, 32'h103, 32'h0,        5'd8,  1, 32'h8000_0000, 2,
              32'hFFFF_FF80, 4'b1000, 32'h0);
        memOp("LBU", 1, 0, SZ_BYTE, 0, 32'h103, 32'h0,        5'd9,  1, 32'h8000_0000, 1,
              32'h0000_0080, 4'b1000, 32'h0);
        memOp("SH",  0, 1, SZ_HALF, 0, 32'h202, 32'h0000_ABCD, 5'd0, 0, 32'h1111_1111, 4,
              32'h0, 4'b1100, 32'hABCD_ABCD);
        memOp("SB",  0, 1, SZ_BYTE, 0, 32'h301, 32'h1234_5677, 5'd0, 0, 32'h2222_2222, 3,
              32'h0, 4'b0010, 32'h7777_7777);
        memOp("LH",  1, 0, SZ_HALF, 1, 32'h102, 32'h0,        5'd10, 1, 32'h8001_7FFF, 1,
              32'hFFFF_8001, 4'b1100, 32'h0);
        memOp("LHU", 1, 0, SZ_HALF, 0, 32'h100, 32'h0,        5'd11, 1, 32'h8001_F00F, 2,
              32'h0000_F00F, 4'b0011, 32'h0);
        memOp("LBpos", 1, 0, SZ_BYTE, 1, 32'h101, 32'h0,      5'd12, 1, 32'h0000_7F00, 1,
              32'h0000_007F, 4'b0010, 32'h0);
`ifdef MEM_TIMEOUT_EN
        memOp("TMO", 1, 0, SZ_WORD, 0, 32'h400, 32'h0,        5'd13, 1, 32'h0, 0,
              32'h0, 4'b1111, 32'h0);
`endif

        // Reset in the middle of WAIT abandons the access.
        valid_in = 1; MemReadIN = 1; MemSizeIN = SZ_WORD; MemtoRegIN = 1; RegWriteIN = 1;
        ALU_IN = 32'h500; DestinoIN = 5'd14;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        idle();
        @(negedge clk);
        chk("rstwait req_before", 32'(mem_req), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstwait req",   32'(mem_req),   32'h0);
        chk("rstwait stall", 32'(stall_out), 32'h0);
        chk("rstwait addr",  mem_addr,       32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        // Stray ack while IDLE must not disturb a pass-through.
        valid_in = 1; RegWriteIN = 1; ALU_IN = 32'h77; DestinoIN = 5'd2; mem_ack = 1;
        @(negedge clk);
        chk("idle_ack RegWrite", 32'(RegWriteOUT), 32'h1);
        chk("idle_ack stall",    32'(stall_out),   32'h0);
        chk("idle_ack ALU_OUT",  ALU_OUT,          32'h77);
        @(posedge clk); #1;
        mem_ack = 0;
        ALU_IN = 32'h88;
        @(negedge clk);
        chk("post_ack ALU_OUT",  ALU_OUT,          32'h88);
        chk("post_ack RegWrite", 32'(RegWriteOUT), 32'h1);
        chk("post_ack req",      32'(mem_req),     32'h0);
        chk("sb drained",        32'(sb.size()),   32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage between EX_MEM and MEM_WB. Performs loads/stores to data memory over a req/ack bus. Handles byte/half/word sizing and load sign extension. Stalls the upstream pipeline while an access is outstanding and presents bubbles to MEM_WB until the access completes; non-memory instructions pass through with zero latency.

## Interface
- TIMEOUT_CYCLES, 255: WAIT cycles before abort; used only with MEM_TIMEOUT_EN; legal range 1..65535.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- valid_in  in  1  EX_MEM holds a real instruction.
- MemReadIN, MemWriteIN  in  1 each  load / store; never both high.
- MemSizeIN  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- MemSignedIN  in  1  sign-extend sub-word loads.
- MemtoRegIN, RegWriteIN  in  1 each  WB controls from EX_MEM.
- ALU_IN  in  32  effective address / ALU result.
- WriteDataIN  in  32  store data, right-aligned.
- DestinoIN  in  5  destination register.
- mem_req, mem_we  out  1 each  bus request / write strobe.
- mem_addr  out  32  word-aligned address ({ALU_IN[31:2],2'b00}).
- mem_be  out  4  byte enables, little-endian lanes.
- mem_wdata  out  32  lane-steered store data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- MemtoRegOUT, RegWriteOUT  out  1 each  to MEM_WB.
- dataOUT, ALU_OUT  out  32 each  load result / pass-through ALU value.
- DestinoOUT  out  5  to MEM_WB.
- stall_out  out  1  freeze PC, IF_ID, ID_EX, EX_MEM.
- misalign_out, mem_err  out  1 each  one-cycle fault pulses.

## Operation
- FSM states IDLE, WAIT, DONE.
- IDLE, no mem op (valid_in=0 or both Mem* low): outputs combinationally follow inputs; dataOUT=0; stall_out=0.
- IDLE, mem op, aligned: stall_out=1, latch address/data/controls, RegWriteOUT=0 (bubble), go WAIT.
- Misaligned (half with addr[0]=1; word with addr[1:0]!=0): no bus access, misalign_out=1 for that cycle, RegWriteOUT=0, stall_out=0, stay IDLE.
- WAIT: mem_req=1, bus outputs stable from latches, stall_out=1, bubble to MEM_WB.
  - On mem_ack: capture aligned/extended rdata (loads), drop mem_req next edge, go DONE.
- DONE: stall_out=0; outputs driven from latches (RegWriteOUT = latched RegWriteIN); EX_MEM inputs ignored; go IDLE.
- Store lanes: byte -> data[7:0] replicated, be=1<<addr[1:0]; half -> be=0011/1100; word -> be=1111.
- Load: select lane by addr[1:0]; zero- or sign-extend per MemSignedIN.
- Stores return dataOUT=0.

## Timing
- Reset (rst_n=0 at edge): state IDLE, mem_req/mem_we=0, mem_be=0, mem_addr/mem_wdata=0, latches 0, misalign_out/mem_err=0.
  - Reset mid-WAIT abandons the access; mem_req low after that edge.
- Pass-through latency 0; memory op occupies stage ≥3 cycles (entry, ≥1 WAIT, DONE); stall_out high entry+WAIT cycles.
- mem_ack in first WAIT cycle is legal (minimum case: 2 stall cycles).
- mem_ack outside WAIT is ignored.
- mem_req is registered and never deasserts before ack, abort or reset.

## Configuration
- MEM_TIMEOUT_EN defined: 16-bit counter cleared on WAIT entry.
  - At TIMEOUT_CYCLES WAIT cycles without ack: drop mem_req, pulse mem_err, go DONE with RegWriteOUT=0 and dataOUT=0.
  - An ack on the timeout cycle wins.
- Undefined: WAIT is unbounded; mem_err tied 0; no counter logic.

## Structure
- Package mem_pkg: FSM state enum, MemSizeIN codes (SZ_BYTE/SZ_HALF/SZ_WORD), misalignment function.
- Sub-module mem_load_align: combinational lane selection and sign extension of mem_rdata; store steering stays inline.

## Test plan
- ADD, ALU_IN=0x1234, RegWriteIN=1, Dest=5 -> same-cycle pass-through, ALU_OUT=0x1234, stall_out=0.
- LW addr 0x100, ack in first WAIT with rdata 0xDEADBEEF -> stall 2 cycles, DONE dataOUT=0xDEADBEEF, RegWriteOUT=1 only in DONE.
- LB signed addr 0x103, rdata 0x80000000 -> dataOUT=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202, data 0xABCD -> mem_be=1100, mem_wdata[31:16]=0xABCD, mem_we=1 until ack after 4 cycles.
- LW addr 0x101 -> misalign_out pulse, mem_req never rises, RegWriteOUT=0, no stall.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_err pulse after 4 WAIT cycles, RegWriteOUT=0. Separately, rst_n low mid-WAIT -> mem_req=0 next cycle, state IDLE.
